push_button_conditioner: RTL and testbench



---
 rtl/push_button_conditioner_pkg.sv | 32 +++
 rtl/push_button_conditioner_debounce.sv | 129 ++++++++++++
 rtl/push_button_conditioner.sv | 47 ++++
 tb/tb_push_button_conditioner.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/push_button_conditioner_pkg.sv
// Shared definitions for the push-button input path.
//   - Button index constants matching the push[] bit order (u, d, l, r, m).
//   - Default timing constants for a 100 MHz clk_osc.
//   - Encoding of the per-button auto-repeat state machine.
//   - cnt_width(): counter width for a terminal count, never below 1 bit.
package push_button_conditioner_pkg;

  localparam int unsigned BTN_U = 0;
  localparam int unsigned BTN_D = 1;
  localparam int unsigned BTN_L = 2;
  localparam int unsigned BTN_R = 3;
  localparam int unsigned BTN_M = 4;

  localparam int unsigned DEFAULT_N_BTN           = 5;
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 1_000_000;   // 10 ms
  localparam int unsigned DEFAULT_REPEAT_DELAY    = 50_000_000;  // 0.5 s
  localparam int unsigned DEFAULT_REPEAT_RATE     = 15_000_000;  // 0.15 s
  localparam logic [4:0]  DEFAULT_REPEAT_MASK     = 5'b00011;    // up, down

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rpt_state_t;

  // A counter that counts 0..n-1 needs $clog2(n) bits; a count of 1 or 2
  // still needs a real flop so the vector is never zero-width.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/push_button_conditioner_debounce.sv
// Single-button conditioner: two-flop synchroniser, debounce counter and an
// optional auto-repeat state machine.
// Ports:
//   clk_osc        system clock
//   reset          synchronous, active-high reset
//   push           raw asynchronous button level
//   level          debounced level
//   press          one-cycle pulse on accepted press and on each auto-repeat
//   release_pulse  one-cycle pulse on accepted release ("release" itself is
//                  a reserved word in SystemVerilog)
module button_debounce_repeat
  import push_button_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter bit          REPEAT_EN       = 1'b1,
  parameter int unsigned REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
  parameter int unsigned REPEAT_RATE     = DEFAULT_REPEAT_RATE
) (
  input  logic clk_osc,
  input  logic reset,
  input  logic push,
  output logic level,
  output logic press,
  output logic release_pulse
);

  localparam int unsigned DW = cnt_width(DEBOUNCE_CYCLES);
  localparam int unsigned RW = (cnt_width(REPEAT_DELAY) > cnt_width(REPEAT_RATE))
                               ? cnt_width(REPEAT_DELAY) : cnt_width(REPEAT_RATE);

  localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);

  logic [1:0]    sync_q;   // [0] first stage, [1] synchronised level
  logic          sync;
  logic [DW-1:0] cnt;
  logic          accept;
  logic          rise;
  logic          fall;

  rpt_state_t    state;
  rpt_state_t    state_nxt;
  logic [RW-1:0] rcnt;
  logic [RW-1:0] rcnt_nxt;
  logic          rpt_pulse;

  assign sync   = sync_q[1];
  // The new level has persisted for DEBOUNCE_CYCLES samples: take it now.
  assign accept = (sync != level) && (cnt == DB_LAST);
  assign rise   = accept &  sync;
  assign fall   = accept & ~sync;

  always_comb begin
    // NOTE: every output of this block gets a default before any branch so
    // no path leaves one unassigned, which would infer a latch.
    state_nxt = state;
    rcnt_nxt  = rcnt;
    rpt_pulse = 1'b0;

    // A release always wins: back to IDLE and no repeat pulse this cycle.
    if (!REPEAT_EN || fall) begin
      state_nxt = IDLE;
      rcnt_nxt  = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (rise) begin
            state_nxt = DELAY;
            rcnt_nxt  = '0;
          end
        end
        DELAY: begin
          if (rcnt == DELAY_LAST) begin
            rpt_pulse = 1'b1;
            rcnt_nxt  = '0;
            state_nxt = REPEAT;
          end else begin
            rcnt_nxt = rcnt + RW'(1);
          end
        end
        REPEAT: begin
          if (rcnt == RATE_LAST) begin
            rpt_pulse = 1'b1;
            rcnt_nxt  = '0;
          end else begin
            rcnt_nxt = rcnt + RW'(1);
          end
        end
        default: begin
          state_nxt = IDLE;
          rcnt_nxt  = '0;
        end
      endcase
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop here
  // samples values from before the edge, regardless of statement order.
  always_ff @(posedge clk_osc) begin
    if (reset) begin
      sync_q        <= '0;
      level         <= 1'b0;
      cnt           <= '0;
      state         <= IDLE;
      rcnt          <= '0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], push};

      if (sync == level) begin
        cnt <= '0;            // bounce back to the current level: start over
      end else if (cnt == DB_LAST) begin
        level <= sync;
        cnt   <= '0;
      end else begin
        cnt <= cnt + DW'(1);
      end

      state         <= state_nxt;
      rcnt          <= rcnt_nxt;
      // Pulses are registered so they line up with the level change.
      press         <= rise | rpt_pulse;
      release_pulse <= fall;
    end
  end

endmodule

// File: rtl/push_button_conditioner.sv
// Turns the raw push buttons into clean, clock-synchronous events.
// Ports:
//   clk_osc        system clock (100 MHz)
//   reset          synchronous, active-high reset
//   push           raw button levels, push[0]=u, [1]=d, [2]=l, [3]=r, [4]=m
//   level          debounced button levels
//   press          one-cycle pulse per accepted press and per auto-repeat
//   release_pulse  one-cycle pulse per accepted release
//   any_press      OR of press, same cycle
module push_button_conditioner
  import push_button_conditioner_pkg::*;
#(
  parameter int unsigned       N_BTN           = DEFAULT_N_BTN,
  parameter int unsigned       DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter logic [N_BTN-1:0]  REPEAT_MASK     = N_BTN'(DEFAULT_REPEAT_MASK),
  parameter int unsigned       REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
  parameter int unsigned       REPEAT_RATE     = DEFAULT_REPEAT_RATE
) (
  input  logic             clk_osc,
  input  logic             reset,
  input  logic [N_BTN-1:0] push,
  output logic [N_BTN-1:0] level,
  output logic [N_BTN-1:0] press,
  output logic [N_BTN-1:0] release_pulse,
  output logic             any_press
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    button_debounce_repeat #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_EN       (REPEAT_MASK[i]),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_RATE     (REPEAT_RATE)
    ) u_btn (
      .clk_osc       (clk_osc),
      .reset         (reset),
      .push          (push[i]),
      .level         (level[i]),
      .press         (press[i]),
      .release_pulse (release_pulse[i])
    );
  end

  // Press is already registered, so this OR lands in the same cycle.
  assign any_press = |press;

endmodule

// File: tb/tb_push_button_conditioner.sv
// Directed bench for push_button_conditioner with DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=10, REPEAT_RATE=3, REPEAT_MASK=5'b00011.
// Cycle c means "just after the c-th rising edge since the scenario began";
// inputs changed at cycle c are first sampled at edge c+1.
module tb_push_button_conditioner;

  logic       clk_osc;
  logic       reset;
  logic [4:0] push;
  logic [4:0] level;
  logic [4:0] press;
  logic [4:0] release_pulse;
  logic       any_press;

  int total;
  int bad;

  push_button_conditioner #(
    .N_BTN           (5),
    .DEBOUNCE_CYCLES (4),
    .REPEAT_MASK     (5'b00011),
    .REPEAT_DELAY    (10),
    .REPEAT_RATE     (3)
  ) dut (
    .clk_osc       (clk_osc),
    .reset         (reset),
    .push          (push),
    .level         (level),
    .press         (press),
    .release_pulse (release_pulse),
    .any_press     (any_press)
  );

  initial clk_osc = 1'b0;
  always #5 clk_osc = ~clk_osc;

  task automatic tick();
    @(posedge clk_osc);
    #1;
  endtask

  task automatic drain();
    push = '0;
    repeat (12) tick();
  endtask

  // Reset with all buttons held: nothing may come out; afterwards idle.
  task automatic test_reset();
    logic [15:0] got;
    reset = 1'b1;
    push  = 5'b11111;
    for (int c = 1; c <= 8; c++) begin
      tick();
      got = {level, press, release_pulse, any_press};
      total++;
      if (got !== 16'h0000) begin
        bad++;
        $display("FAIL reset c=%0d got=%b want=%b", c, got, 16'h0000);
      end
    end
    push  = '0;
    reset = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      tick();
      got = {level, press, release_pulse, any_press};
      total++;
      if (got !== 16'h0000) begin
        bad++;
        $display("FAIL reset_idle c=%0d got=%b want=%b", c, got, 16'h0000);
      end
    end
  endtask

  // Clean press of m held 8 cycles: one press at 6, release at 8+6=14.
  task automatic test_press_release();
    logic [15:0] got, want;
    logic [4:0]  ep, er, el;
    push = 5'b10000;
    for (int c = 1; c <= 20; c++) begin
      tick();
      ep   = (c == 6) ? 5'b10000 : 5'b00000;
      er   = (c == 14) ? 5'b10000 : 5'b00000;
      el   = (c >= 6 && c < 14) ? 5'b10000 : 5'b00000;
      want = {el, ep, er, |ep};
      got  = {level, press, release_pulse, any_press};
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL press_release c=%0d got=%b want=%b", c, got, want);
      end
      if (c == 8) push[4] = 1'b0;
    end
    drain();
  endtask

  // u held 31 cycles: press at 6, 16, then every 3; the fall lands at 37,
  // exactly where a repeat would be due, and must suppress it.
  task automatic test_auto_repeat();
    logic [15:0] got, want;
    logic [4:0]  ep, er, el;
    push = 5'b00001;
    for (int c = 1; c <= 40; c++) begin
      tick();
      ep   = (c == 6 || (c >= 16 && c < 37 && ((c - 16) % 3) == 0)) ? 5'b00001 : 5'b00000;
      er   = (c == 37) ? 5'b00001 : 5'b00000;
      el   = (c >= 6 && c < 37) ? 5'b00001 : 5'b00000;
      want = {el, ep, er, |ep};
      got  = {level, press, release_pulse, any_press};
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL auto_repeat c=%0d got=%b want=%b", c, got, want);
      end
      if (c == 31) push[0] = 1'b0;
    end
    drain();
  endtask

  // l bounces 1,0,1,0 then holds from cycle 4: single press at 10, no
  // repeat (mask bit clear), release 6 after the fall at 30.
  task automatic test_bounce_no_repeat();
    logic [15:0] got, want;
    logic [4:0]  ep, er, el;
    push = 5'b00100;
    for (int c = 1; c <= 38; c++) begin
      tick();
      ep   = (c == 10) ? 5'b00100 : 5'b00000;
      er   = (c == 36) ? 5'b00100 : 5'b00000;
      el   = (c >= 10 && c < 36) ? 5'b00100 : 5'b00000;
      want = {el, ep, er, |ep};
      got  = {level, press, release_pulse, any_press};
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL bounce c=%0d got=%b want=%b", c, got, want);
      end
      if (c == 1 || c == 3 || c == 30) push[2] = 1'b0;
      if (c == 2 || c == 4)            push[2] = 1'b1;
    end
    drain();
  endtask

  // d and r together: joint press at 6, joint release at 14.
  task automatic test_simultaneous();
    logic [15:0] got, want;
    logic [4:0]  ep, er, el;
    push = 5'b01010;
    for (int c = 1; c <= 16; c++) begin
      tick();
      ep   = (c == 6) ? 5'b01010 : 5'b00000;
      er   = (c == 14) ? 5'b01010 : 5'b00000;
      el   = (c >= 6 && c < 14) ? 5'b01010 : 5'b00000;
      want = {el, ep, er, |ep};
      got  = {level, press, release_pulse, any_press};
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL simultaneous c=%0d got=%b want=%b", c, got, want);
      end
      if (c == 8) push = 5'b00000;
    end
    drain();
  endtask

  // u in REPEAT, reset sampled at edge 21: all zero at 21, fresh press at
  // 27, repeats at 37 and 40; reset gives no release pulse.
  task automatic test_reset_mid_hold();
    logic [15:0] got, want;
    logic [4:0]  ep, el;
    push = 5'b00001;
    for (int c = 1; c <= 41; c++) begin
      tick();
      ep   = (c == 6 || c == 16 || c == 19 || c == 27 || c == 37 || c == 40)
             ? 5'b00001 : 5'b00000;
      el   = ((c >= 6 && c <= 20) || c >= 27) ? 5'b00001 : 5'b00000;
      want = {el, ep, 5'b00000, |ep};
      got  = {level, press, release_pulse, any_press};
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL reset_mid_hold c=%0d got=%b want=%b", c, got, want);
      end
      if (c == 20) reset = 1'b1;
      if (c == 21) reset = 1'b0;
    end
    drain();
  endtask

  // m held, low for 3 cycles (10..12): one short of the debounce window,
  // so level stays high and no extra pulses appear.
  task automatic test_glitch_hold();
    logic [15:0] got, want;
    logic [4:0]  ep, el;
    push = 5'b10000;
    for (int c = 1; c <= 24; c++) begin
      tick();
      ep   = (c == 6) ? 5'b10000 : 5'b00000;
      el   = (c >= 6) ? 5'b10000 : 5'b00000;
      want = {el, ep, 5'b00000, |ep};
      got  = {level, press, release_pulse, any_press};
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL glitch_hold c=%0d got=%b want=%b", c, got, want);
      end
      if (c == 10) push[4] = 1'b0;
      if (c == 13) push[4] = 1'b1;
    end
    drain();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    push  = '0;
    test_reset();
    test_press_release();
    test_auto_repeat();
    test_bounce_no_repeat();
    test_simultaneous();
    test_reset_mid_hold();
    test_glitch_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
